bme280_uart_streamer: RTL and testbench

- Sits directly downstream of the BME280 I2C reader.
- Captures each 96-bit measurement frame and its 2-bit error code on the reader's valid strobe, then buffers the frames in a small FIFO.
- Serializes each frame as a framed, checksummed 15-byte packet on an 8N1 UART TX line for board-level logging.
- Reports overflow drops and busy state back to the control logic.

---
 rtl/bme280_uart_streamer.sv | 166 ++++++++++++++++
 tb/tb_bme280_uart_streamer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bme280_uart_streamer.sv
// Buffers BME280 measurement frames in a small FIFO and streams each one as a
// 15-byte framed, checksummed packet on an 8N1 UART transmit line.
module bme280_uart_streamer #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         DEPTH        = 4,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [95:0]              in_data,
  input  logic [1:0]               in_error,
  input  logic                     in_valid,
  output logic                     uart_tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t          state_r;
  logic [97:0]     mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic [7:0]      drop_r;
  logic            busy_r;
  logic            tx_r;
  logic [5:0]      seq_r;
  logic [119:0]    pkt_r;
  logic [3:0]      byte_idx_r;
  logic [2:0]      bit_idx_r;
  logic [CW-1:0]   clk_cnt_r;

  logic            full_s, push_s, pop_s, tick_s, last_s, idle_next_s;
  logic [LW-1:0]   level_next_s;
  logic [97:0]     head_s;
  logic [7:0]      hdr_s, cur_byte_s;

  function automatic logic [7:0] packet_checksum(input logic [7:0] hdr, input logic [95:0] data);
    logic [7:0] sum;
    sum = SYNC_BYTE + hdr;
    for (int i = 0; i < 12; i++) sum = sum + data[8*i +: 8];
    return sum;
  endfunction

  // Fullness is judged on the pre-edge level, so a push racing a pop on full still drops.
  always_comb begin
    full_s       = (level_r == LVL_FULL);
    push_s       = in_valid & ~full_s;
    pop_s        = (state_r == LOAD);
    tick_s       = (clk_cnt_r == CNT_MAX);
    last_s       = (state_r == STOP) & tick_s & (byte_idx_r == 4'd14);
    head_s       = mem_r[rd_ptr_r];
    hdr_s        = {seq_r, head_s[97:96]};
    cur_byte_s   = pkt_r[119:112];
    level_next_s = level_r + LW'(push_s) - LW'(pop_s);
    if (state_r == IDLE) idle_next_s = (level_r == LVL_ZERO);
    else                 idle_next_s = last_s;
  end

  // Frame storage (no reset needed: entries are only read after being written).
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= {in_error, in_data};
  end

  // FIFO pointers, level, drop counter and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= LVL_ZERO;
      drop_r   <= 8'd0;
      busy_r   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      if (in_valid && full_s && (drop_r != 8'hFF)) drop_r <= drop_r + 8'd1;
      level_r <= level_next_s;
      busy_r  <= (level_next_s != LVL_ZERO) | ~idle_next_s;
    end
  end

  // Packet FSM with registered serial output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      tx_r       <= 1'b1;
      seq_r      <= 6'd0;
      pkt_r      <= 120'd0;
      byte_idx_r <= 4'd0;
      bit_idx_r  <= 3'd0;
      clk_cnt_r  <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          tx_r <= 1'b1;
          if (level_r != LVL_ZERO) state_r <= LOAD;
        end
        LOAD: begin
          pkt_r      <= {SYNC_BYTE, hdr_s, head_s[95:0], packet_checksum(hdr_s, head_s[95:0])};
          byte_idx_r <= 4'd0;
          clk_cnt_r  <= {CW{1'b0}};
          tx_r       <= 1'b0;
          state_r    <= START;
        end
        START: begin
          if (tick_s) begin
            clk_cnt_r <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            tx_r      <= cur_byte_s[0];
            state_r   <= DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (tick_s) begin
            clk_cnt_r <= {CW{1'b0}};
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= cur_byte_s[bit_idx_r + 3'd1];
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
          end
        end
        STOP: begin
          if (tick_s) begin
            clk_cnt_r <= {CW{1'b0}};
            if (byte_idx_r < 4'd14) begin
              byte_idx_r <= byte_idx_r + 4'd1;
              pkt_r      <= {pkt_r[111:0], 8'h00};
              tx_r       <= 1'b0;
              state_r    <= START;
            end else begin
              seq_r   <= seq_r + 6'd1;
              state_r <= IDLE;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
          end
        end
        default: begin
          tx_r    <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign uart_tx    = tx_r;
  assign busy       = busy_r;
  assign fifo_level = level_r;
  assign drop_count = drop_r;

endmodule

// File: tb/tb_bme280_uart_streamer.sv
// Self-checking bench for bme280_uart_streamer: a packet-level reference model
// checked every cycle, a UART receiver, and directed literal expectations.
module tb_bme280_uart_streamer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [95:0] in_data = 96'd0;
  logic [1:0]  in_error = 2'd0;
  logic        in_valid = 1'b0;
  logic        uart_tx;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;

  int tests = 0;
  int fails = 0;

  bme280_uart_streamer #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_error(in_error),
    .in_valid(in_valid), .uart_tx(uart_tx), .busy(busy),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [97:0]  mq[$];
  logic [149:0] m_bits;
  int           m_pos;
  int           m_drop;
  logic [5:0]   m_seq;
  bit           m_active, m_loading, m_tx;

  function automatic logic [7:0] model_csum(input logic [97:0] f, input logic [5:0] s);
    int sum;
    sum = 'hA5 + int'({s, f[97:96]});
    for (int i = 0; i < 12; i++) sum += int'(f[8*i +: 8]);
    return 8'(sum % 256);
  endfunction

  // Line level for every bit period of a packet: start, 8 data LSB first, stop.
  function automatic logic [149:0] model_bits(input logic [97:0] f, input logic [5:0] s);
    logic [7:0]   by [15];
    logic [149:0] v;
    by[0] = 8'hA5;
    by[1] = {s, f[97:96]};
    for (int i = 0; i < 12; i++) by[2+i] = f[95-8*i -: 8];
    by[14] = model_csum(f, s);
    for (int b = 0; b < 15; b++) begin
      v[b*10] = 1'b0;
      for (int k = 0; k < 8; k++) v[b*10+1+k] = by[b][k];
      v[b*10+9] = 1'b1;
    end
    return v;
  endfunction

  task automatic model_step();
    int          sz_pre;
    bit          full;
    bit          do_pop;
    logic [97:0] f;
    f = 98'd0;
    if (!reset_n) begin
      mq.delete();
      m_drop = 0; m_seq = 6'd0; m_active = 0; m_loading = 0; m_pos = 0; m_tx = 1;
      return;
    end
    sz_pre = mq.size();
    full   = (sz_pre == DEPTH);
    do_pop = m_loading;
    if (do_pop) f = mq.pop_front();
    if (in_valid) begin
      if (full) begin
        if (m_drop < 255) m_drop++;
      end else mq.push_back({in_error, in_data});
    end
    if (do_pop) begin
      m_bits = model_bits(f, m_seq);
      m_active = 1; m_pos = 0; m_loading = 0; m_tx = 0;
    end else if (m_active) begin
      m_pos++;
      if (m_pos == 150*CPB) begin
        m_active = 0; m_seq = m_seq + 6'd1; m_tx = 1;
      end else m_tx = m_bits[m_pos/CPB];
    end else if (sz_pre != 0) m_loading = 1;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      check("tx",    uart_tx, m_tx);
      check("level", fifo_level, mq.size());
      check("drop",  drop_count, m_drop);
      check("busy",  busy, (mq.size() != 0) || m_active || m_loading);
    end
  end

  // ---------------- UART receiver ----------------
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;
  initial forever begin
    @(negedge clk);
    if (reset_n && uart_tx == 1'b0) begin
      repeat (CPB+1) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        rx_b[k] = uart_tx;
        repeat (CPB) @(negedge clk);
      end
      rx_q.push_back(rx_b);
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rx_q.delete();
  endtask

  task automatic send_frame(input logic [95:0] d, input logic [1:0] e);
    in_data = d; in_error = e; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin @(negedge clk); c++; end
    check("rx byte count", rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin @(negedge clk); c++; end
    check("idle timeout", busy, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_load(input int budget);
    int c = 0;
    do begin @(negedge clk); c++; end while (!m_loading && c < budget);
    check("load reached", m_loading, 1'b1);
  endtask

  logic [7:0] exp_pkt [15];

  initial begin
    int c;
    // model pin: checksum of the reference packet
    check("model csum", model_csum({2'b01, 96'h0102030405060708090A0B0C}, 6'd0), 8'hF4);

    // 1) reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst tx", uart_tx, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst level", fifo_level, 3'd0);
    check("rst drop", drop_count, 8'd0);

    // 2) all-zero frame: latency, bytes, duration
    send_frame(96'h0, 2'b00);
    check("lat edge0", uart_tx, 1'b1);
    @(negedge clk); check("lat edge1", uart_tx, 1'b1);
    @(negedge clk); check("lat edge2", uart_tx, 1'b0);
    c = 0;
    while (busy && c < 700) begin @(negedge clk); c++; end
    check("packet clks", c, 600);
    wait_bytes(15, 50);
    for (int i = 0; i < 15; i++)
      check("zero pkt byte", rx_q[i], (i == 0 || i == 14) ? 8'hA5 : 8'h00);
    wait_idle(100);

    // 3) counting frame, twice back to back
    do_reset();
    exp_pkt[0] = 8'hA5; exp_pkt[1] = 8'h01; exp_pkt[14] = 8'hF4;
    for (int i = 0; i < 12; i++) exp_pkt[2+i] = 8'(i+1);
    send_frame(96'h0102030405060708090A0B0C, 2'b01);
    send_frame(96'h0102030405060708090A0B0C, 2'b01);
    wait_bytes(30, 1400);
    for (int i = 0; i < 15; i++) check("cnt pkt byte", rx_q[i], exp_pkt[i]);
    check("pkt2 sync", rx_q[15], 8'hA5);
    check("pkt2 hdr", rx_q[16], 8'h05);
    check("pkt2 csum", rx_q[29], 8'hF8);
    wait_idle(200);

    // 4) six consecutive frames: one drop, five packets seq 0..4
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_data = {88'd0, 8'(i+1)}; in_error = 2'b00; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("burst drop", drop_count, 8'd1);
    check("burst level", fifo_level, 3'd4);
    wait_bytes(75, 3300);
    for (int p = 0; p < 5; p++) begin
      check("burst sync", rx_q[p*15], 8'hA5);
      check("burst seq", rx_q[p*15+1], 8'(p << 2));
      check("burst data", rx_q[p*15+13], 8'(p+1));
    end
    wait_idle(200);
    repeat (50) @(negedge clk);
    check("burst pkt total", rx_q.size(), 75);

    // 5) drop counter saturation
    do_reset();
    for (int i = 0; i < 310; i++) begin
      in_data = 96'(i); in_error = 2'b10; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("drop saturate", drop_count, 8'd255);
    wait_idle(3500);
    check("drop held", drop_count, 8'd255);

    // 6) reset in the middle of byte 7
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_data = 96'hDEAD_BEEF_0000 + 96'(i); in_error = 2'b11; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre-rst drop", drop_count, 8'd1);
    wait_bytes(7, 400);
    repeat (10) @(negedge clk);
    check("pre-rst tx data", uart_tx == m_tx, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid rst tx", uart_tx, 1'b1);
    check("mid rst level", fifo_level, 3'd0);
    check("mid rst drop", drop_count, 8'd0);
    check("mid rst busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    rx_q.delete();
    send_frame(96'h0, 2'b10);
    wait_bytes(15, 700);
    check("post-rst sync", rx_q[0], 8'hA5);
    check("post-rst seq", rx_q[1], 8'h02);
    wait_idle(100);

    // 7) push exactly on the LOAD pop: full drops, level 2 holds
    do_reset();
    send_frame(96'h11, 2'b00);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_data = 96'h20 + 96'(i); in_error = 2'b00; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("fill level", fifo_level, 3'd4);
    wait_load(700);
    check("load level full", fifo_level, 3'd4);
    send_frame(96'h99, 2'b01);
    check("pop-full level", fifo_level, 3'd3);
    check("pop-full drop", drop_count, 8'd1);
    wait_load(700);
    wait_load(700);
    check("load level two", fifo_level, 3'd2);
    send_frame(96'h77, 2'b01);
    check("pop-push level", fifo_level, 3'd2);
    check("pop-push drop", drop_count, 8'd1);
    wait_idle(4000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
